// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the receiver and the future transmitter
//   rx_state_t      : receiver FSM states
//   UART_DATA_BITS  : payload bits per frame
//   UART_IDLE_LEVEL : line level when no frame is in flight
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;
    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-period counter with half-period and full-period terminal pulses
//   clk     in  system clock, rising edge
//   n_rst   in  asynchronous active-low reset
//   i_clear in  restart the count from 0 on the next edge
//   o_half  out high while the count sits on CLKS_PER_BIT/2-1 (mid start bit)
//   o_full  out high while the count sits on CLKS_PER_BIT-1 (one bit period done)
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    output logic o_half,
    output logic o_full
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    logic [TW-1:0] r_cnt;
    assign o_half = r_cnt == HALF_LAST;
    assign o_full = r_cnt == FULL_LAST;
    // Wrap at the full-period terminal so DATA/STOP sampling repeats without a clear.
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) r_cnt <= '0;
        else        r_cnt <= (i_clear || o_full) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with sticky data_ready, framing and overrun flags
//   clk           in  system clock, rising edge
//   n_rst         in  asynchronous active-low reset
//   serial_in     in  raw RX line, idle high, asynchronous to clk
//   data_read     in  consumer acknowledge; clears data_ready and both error flags
//   rx_data       out last good byte received
//   data_ready    out high while rx_data holds an unread byte
//   framing_error out sticky: last frame had a low stop bit
//   overrun_error out sticky: a byte completed while data_ready was still set
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    input  logic       data_read,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun_error
);
    localparam int BCW = $clog2(UART_DATA_BITS);
    logic [SYNC_STAGES-1:0]    r_sync;
    logic                      r_rx_d;
    rx_state_t                 r_state, w_next;
    logic [BCW-1:0]            r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic w_rx_s, w_clear, w_half, w_full, w_bit_last, w_stop_tick, w_good, w_bad;
    assign w_rx_s      = r_sync[SYNC_STAGES-1];
    assign w_bit_last  = r_bit_cnt == BCW'(UART_DATA_BITS - 1);
    assign w_stop_tick = (r_state == STOP) && w_full;
    assign w_good      = w_stop_tick && w_rx_s;
    assign w_bad       = w_stop_tick && !w_rx_s;
    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_clear(w_clear),
        .o_half (w_half),
        .o_full (w_full)
    );
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            r_sync <= {SYNC_STAGES{UART_IDLE_LEVEL}};
            r_rx_d <= UART_IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], serial_in};
            r_rx_d <= w_rx_s;
        end
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_next;
    // The timer is held clear in IDLE so START counts from the detected edge.
    always_comb begin
        w_next  = r_state;
        w_clear = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                if (r_rx_d && !w_rx_s) w_next = START;
            end
            START: if (w_half) begin
                w_clear = 1'b1;
                w_next  = w_rx_s ? IDLE : DATA;
            end
            DATA:      if (w_full && w_bit_last) w_next = STOP;
            STOP:      if (w_full) w_next = w_rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (w_rx_s) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end
    // LSB arrives first, so each new bit enters at the MSB and moves down.
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == START && w_half) r_bit_cnt <= '0;
            else if (r_state == DATA && w_full) r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_state == DATA && w_full) r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
        end
    // An acknowledge in the completion cycle counts as having consumed the old byte,
    // so no overrun; a framing failure in that cycle still raises its flag.
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (w_good) rx_data <= r_shift;
            data_ready    <= w_good || (data_ready && !data_read);
            framing_error <= w_bad || (framing_error && !data_read);
            overrun_error <= !data_read && (overrun_error || (w_good && data_ready));
        end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed self-checking bench for uart_rx_byte at 16 clocks per bit
module tb_uart_rx_byte;
    localparam int CPB = 16;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready, framing_error, overrun_error;
    int total = 0;
    int bad   = 0;
    uart_rx_byte #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag, input logic [7:0] d, input logic dr, input logic fe, input logic ov);
        chk({tag, ".rx_data"}, rx_data, d);
        chk({tag, ".data_ready"}, {7'd0, data_ready}, {7'd0, dr});
        chk({tag, ".framing_error"}, {7'd0, framing_error}, {7'd0, fe});
        chk({tag, ".overrun_error"}, {7'd0, overrun_error}, {7'd0, ov});
    endtask
    task automatic drive_bit(input logic b, input int n);
        serial_in = b;
        repeat (n) @(negedge clk);
    endtask
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(stop_bit, CPB);
        serial_in = 1'b1;
    endtask
    task automatic pulse_read();
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        n_rst     = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (3) @(negedge clk);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        chk_all("idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'h41, 1'b1);
        chk_all("byte41", 8'h41, 1'b1, 1'b0, 1'b0);
        pulse_read();
        chk_all("read41", 8'h41, 1'b0, 1'b0, 1'b0);
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        chk_all("overrun", 8'h32, 1'b1, 1'b0, 1'b1);
        pulse_read();
        chk_all("read_overrun", 8'h32, 1'b0, 1'b0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(1'((8'h35 >> i) & 8'h01), CPB);
        drive_bit(1'b0, 3 * CPB);
        chk_all("framing_low", 8'h32, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1, 3 * CPB);
        chk_all("framing_high", 8'h32, 1'b0, 1'b1, 1'b0);
        send_byte(8'h36, 1'b1);
        chk_all("after_framing", 8'h36, 1'b1, 1'b1, 1'b0);
        pulse_read();
        chk_all("read36", 8'h36, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 3 * CPB);
        chk_all("glitch", 8'h36, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'((8'h55 >> i) & 8'h01), CPB);
        drive_bit(1'b1, CPB / 2);
        n_rst = 1'b0;
        @(negedge clk);
        chk_all("midframe_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        drive_bit(1'b1, 3 * CPB);
        chk_all("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_byte(8'h2A, 1'b1);
        chk_all("byte2A", 8'h2A, 1'b1, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        // Start edge on the pin at negedge 0; completion edge is posedge 155
        // (2 sync stages + edge register, half a bit, 8 data bits, one stop period).
        fork
            send_byte(8'h48, 1'b1);
            begin
                repeat (154) @(negedge clk);
                data_read = 1'b1;
                @(negedge clk);
                data_read = 1'b0;
            end
        join
        chk_all("read_on_completion", 8'h48, 1'b1, 1'b0, 1'b0);
        pulse_read();
        chk_all("final_read", 8'h48, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
